mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

  // Which requester owns the ack due in the current cycle.
  typedef enum logic [1:0] {
    PendNone = 2'd0,
    PendI    = 2'd1,
    PendD    = 2'd2
  } pend_e;

  // Requester granted most recently; only meaningful for round-robin.
  typedef enum logic {
    OwnerI = 1'b0,
    OwnerD = 1'b1
  } owner_e;

  localparam int unsigned StarveMaxDefault = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter for one synchronous memory port, full throughput.
// Define MEM_ARBITER_RR_EN for round-robin; default is data priority with fetch starvation override.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,

  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wen,
  output logic              d_gnt,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,

  output logic              m_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wen,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [3:0] StarveMaxW = 4'(STARVE_MAX);

  pend_e      pend_q, pend_d;
  logic [3:0] starve_q, starve_d;
  logic       gnt_i, gnt_d;
`ifdef MEM_ARBITER_RR_EN
  owner_e     last_q, last_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= PendNone;
      starve_q <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_q   <= OwnerD;
`endif
    end else begin
      pend_q   <= pend_d;
      starve_q <= starve_d;
`ifdef MEM_ARBITER_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  // Grant selection; gated by rst_n so no grant leaks out while reset is held.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (rst_n) begin
      if (i_req && d_req) begin
`ifdef MEM_ARBITER_RR_EN
        gnt_i = (last_q == OwnerD);
`else
        gnt_i = (starve_q == StarveMaxW);
`endif
        gnt_d = !gnt_i;
      end else begin
        gnt_i = i_req;
        gnt_d = d_req;
      end
    end
  end

  always_comb begin
    pend_d   = gnt_i ? PendI : (gnt_d ? PendD : PendNone);
    starve_d = '0;
`ifdef MEM_ARBITER_RR_EN
    last_d = last_q;
    if (gnt_i) begin
      last_d = OwnerI;
    end else if (gnt_d) begin
      last_d = OwnerD;
    end
`else
    if (i_req && !gnt_i) begin
      starve_d = (starve_q == StarveMaxW) ? starve_q : starve_q + 4'd1;
    end
`endif
  end

  always_comb begin
    i_gnt   = gnt_i;
    d_gnt   = gnt_d;
    m_en    = gnt_i | gnt_d;
    m_addr  = '0;
    m_wdata = '0;
    m_wen   = 4'b0000;
    if (gnt_d) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_wen   = d_wen;
    end else if (gnt_i) begin
      m_addr  = i_addr;
    end
    i_ack   = (pend_q == PendI);
    d_ack   = (pend_q == PendD);
    i_rdata = m_rdata;
    d_rdata = m_rdata;
  end

endmodule
